mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have these ports; one clock; reset asynchronous, active-high:
  clk       in   1   sole clock, rising edge
  reset     in   1   async active-high reset
  start     in   1   begin operation; sampled only in IDLE
  op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  A         in   32  multiplicand / dividend
  B         in   32  multiplier / divisor
  mthi      in   1   write wdata into HI
  mtlo      in   1   write wdata into LO
  wdata     in   32  MTHI/MTLO data
  busy      out  1   iteration in progress
  done      out  1   one-cycle completion pulse
  hi        out  32  HI register (product[63:32] / remainder)
  lo        out  32  LO register (product[31:0] / quotient)

Function
REQ-002 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-003 IDLE: start=1 at edge E0 SHALL latch A, B, op; state->CALC; iteration count=0.
REQ-004 CALC SHALL perform exactly 32 iterations, one per edge, E1..E32: shift-add multiply, restoring divide, on operand magnitudes.
REQ-005 busy SHALL be 1 exactly in CALC (32 cycles after E0), else 0.
REQ-006 At E32, hi/lo SHALL load the sign-corrected result and state->DONE; done SHALL be 1 for that single cycle only; E33 state->IDLE.
REQ-007 Signed ops (MULT, DIV) SHALL use |A|, |B|: 64-bit product negated if sign(A)!=sign(B); quotient negated if sign(A)!=sign(B); remainder takes sign of A.
REQ-008 Unsigned ops SHALL treat A, B as 0..2^32-1.
REQ-009 DIV/DIVU with B=0 SHALL take the same 32-cycle latency and give lo=32'hFFFFFFFF, hi=A.
REQ-010 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (no trap, no flag).
REQ-011 start SHALL be ignored in CALC and DONE; no queuing.
REQ-012 Inputs A, B, op changing after E0 SHALL not affect the running operation.
REQ-013 mthi/mtlo SHALL write hi/lo at the edge when state is IDLE or DONE; ignored in CALC.
REQ-014 mthi/mtlo and the E32 result load cannot coincide (REQ-013); mthi with start in IDLE SHALL write hi, then the result overwrites hi at E32.
REQ-015 hi/lo SHALL hold value except for writes under REQ-006 and REQ-013.

Reset
REQ-016 reset=1 SHALL asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, latched operands=0.
REQ-017 reset asserted mid-CALC SHALL abandon the operation with no hi/lo update and no done pulse; first start after release SHALL run normally.

Verification
REQ-018 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy 32 cycles; done 1 cycle; hi=0xFFFFFFFE, lo=0x00000001.
REQ-019 MULT A=0xFFFFFFFD(-3) B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
REQ-020 DIV A=0xFFFFFFF9(-7) B=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-021 DIVU A=100 B=0 -> after 32 busy cycles, lo=0xFFFFFFFF, hi=0x00000064.
REQ-022 Start MULTU 5*6; pulse start with other operands and mthi at CALC cycle 10 -> both ignored; result hi=0, lo=30; then mtlo wdata=0x1234 in IDLE -> lo=0x1234.
REQ-023 Start DIVU 100/7; assert reset in CALC cycle 15 -> busy=0, hi=lo=0 immediately, no done; release, DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// One operation at a time: IDLE -> CALC (32 iterations) -> DONE -> IDLE.
// Signed operations iterate on operand magnitudes and fix the signs at the end.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // op[1] selects divide, op[0] selects unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;   // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed, op_div, neg_res, neg_rem;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, r_sh, trial;
  logic [63:0] mul_next, div_next, step, prod;
  logic [31:0] quo, rem;

  // One iteration of shift-add multiply and restoring divide, plus sign correction.
  always_comb begin
    op_signed = ~op_q[0];
    op_div    = op_q[1];
    a_mag     = magnitude(a_q, op_signed);
    b_mag     = magnitude(b_q, op_signed);

    mul_sum  = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? a_mag : 32'd0)};
    mul_next = {mul_sum, p_q[31:1]};

    // Partial remainder stays below the divisor, so a clear borrow bit means "fits".
    r_sh     = p_q[63:31];
    trial    = r_sh - {1'b0, b_mag};
    div_next = trial[32] ? {r_sh[31:0], p_q[30:0], 1'b0}
                         : {trial[31:0], p_q[30:0], 1'b1};

    step    = op_div ? div_next : mul_next;
    neg_res = op_signed & (a_q[31] ^ b_q[31]);
    neg_rem = op_signed & a_q[31];
    prod    = neg_res ? (~step + 64'd1) : step;
    quo     = neg_res ? (~step[31:0] + 32'd1) : step[31:0];
    rem     = neg_rem ? (~step[63:32] + 32'd1) : step[63:32];
  end

  // Next-state, operand latch, iteration and HI/LO write logic.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          count_d = 5'd0;
          op_d    = op;
          a_d     = A;
          b_d     = B;
          p_d     = {32'd0, op[1] ? magnitude(A, ~op[0]) : magnitude(B, ~op[0])};
        end
      end
      S_CALC: begin
        p_d     = step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_DONE;
          if (!op_div) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Move-to-HI/LO is accepted whenever no iteration is running.
    if (state_q != S_CALC) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 5'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      p_q     <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO pushed at start,
// popped and compared when done pulses.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sbv, q, r;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a; sbv = b;
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, mon_exp[63:32]});
        check("sb_lo", {32'd0, lo}, {32'd0, mon_exp[31:0]});
      end
    end
  end

  // Issue one operation; returns at the falling edge after E0 with inputs scrambled.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mthi, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    mthi  = with_mthi; wdata = 32'hBAD0_BAD0;
    if (push) sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
    if (with_mthi) check("mthi_at_start", {32'd0, hi}, 64'hBAD0_BAD0);
  endtask

  // Count busy cycles until done; bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(input int exp_busy);
    int cnt = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_cycles", cnt, exp_busy);
    check("busy_in_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit with_mthi);
    start_op(o, a, b, with_mthi, 1'b1);
    wait_done(32);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;

    // Directed vectors with hand-derived results anchoring the model.
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'd0, lo}, 64'h0000_0001);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, hi}, 64'd0);
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("divu_zero_hi", {32'd0, hi}, 64'd100);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // start/mthi/operand changes during CALC are ignored.
    start_op(OP_MULTU, 32'd5, 32'd6, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; op = OP_MULT; A = 32'd7; B = 32'd9; mthi = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(22);
    check("ign_hi", {32'd0, hi}, 64'd0);
    check("ign_lo", {32'd0, lo}, 64'd30);
    @(negedge clk);
    check("no_queue_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("no_queue_busy", {63'd0, busy}, 64'd0);
    mtlo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle_lo", {32'd0, lo}, 64'h1234);
    check("mtlo_idle_hi", {32'd0, hi}, 64'd0);

    // Write HI during the DONE cycle.
    start_op(OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);
    wait_done(32);
    mthi = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_done_hi", {32'd0, hi}, 64'hCAFE_F00D);
    check("mthi_done_lo", {32'd0, lo}, 64'd12);

    // mthi together with start: the result overwrites HI at completion.
    run_op(OP_DIVU, 32'd1000, 32'd33, 1'b1);

    // Reset in the middle of CALC abandons the operation.
    start_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", {63'd0, done}, 64'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("after_rst_lo", {32'd0, lo}, 64'd14);
    check("after_rst_hi", {32'd0, hi}, 64'd2);

    // Random operations through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(ro, ra, rb, 1'b0);
    end

    check("sb_empty", sb_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
